// File: rtl/cache_lru_writeback.sv
// cache_lru_writeback: fully-associative true-LRU write-back L1 over a latency-modelled backing RAM
// Optional CACHE_STATS_EN adds saturating hit_count/miss_count outputs
module cache_lru_writeback #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LINES = 4,
  parameter int RAM_LAT = 2
) (
  input logic clock,
  input logic reset,
  input logic req_valid,
  output logic req_ready,
  input logic req_write,
  input logic [ADDR_W-1:0] req_addr,
  input logic [DATA_W-1:0] req_wdata,
  output logic resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic resp_hit
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int IW = $clog2(LINES);
  localparam int CW = $clog2(RAM_LAT + 1);
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;
  state_t state, state_nx;
  logic wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [LINES-1:0] valid, dirty;
  logic [ADDR_W-1:0] tag [LINES];
  logic [DATA_W-1:0] data [LINES];
  logic [IW-1:0] age [LINES];
  logic [IW-1:0] idx, hit_idx, inv_idx, old_idx, victim;
  logic hit, inv_any, last, ram_we;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  assign req_ready = state == IDLE && !reset;
  assign resp_valid = state == RESP;
  assign last = cnt == CW'(RAM_LAT - 1);
  assign ram_we = state == WB && last;
  // Descending scan so the lowest-index invalid line wins
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    old_idx = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (valid[i] && tag[i] == addr) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid[i]) begin
        inv_any = 1'b1;
        inv_idx = IW'(i);
      end
      if (age[i] == IW'(LINES - 1)) old_idx = IW'(i);
    end
    victim = inv_any ? inv_idx : old_idx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = req_valid ? LOOKUP : IDLE;
      LOOKUP: state_nx = hit ? RESP : dirty[victim] ? WB : wr ? RESP : FILL;
      WB: state_nx = !last ? WB : wr ? RESP : FILL;
      FILL: state_nx = last ? RESP : FILL;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
      valid <= '0;
      dirty <= '0;
      idx <= '0;
      cnt <= '0;
      resp_rdata <= '0;
      resp_hit <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        tag[i] <= '0;
        data[i] <= '0;
        age[i] <= IW'(i);
      end
    end else begin
      if (req_valid && req_ready) begin
        wr <= req_write;
        addr <= req_addr;
        wdata <= req_wdata;
      end
      cnt <= (state == WB || state == FILL) && !last ? cnt + 1'b1 : '0;
      if (state == LOOKUP) begin
        resp_hit <= hit;
        idx <= hit ? hit_idx : victim;
        if (wr) resp_rdata <= wdata;
        else if (hit) resp_rdata <= data[hit_idx];
        if (hit && wr) begin
          data[hit_idx] <= wdata;
          dirty[hit_idx] <= 1'b1;
        end
        if (!hit && wr && !dirty[victim]) begin
          tag[victim] <= addr;
          data[victim] <= wdata;
          valid[victim] <= 1'b1;
          dirty[victim] <= 1'b1;
        end
      end
      // Write miss over a dirty victim allocates once the eviction lands
      if (ram_we) begin
        dirty[idx] <= wr;
        if (wr) begin
          tag[idx] <= addr;
          data[idx] <= wdata;
          valid[idx] <= 1'b1;
        end
      end
      if (state == FILL && last) begin
        tag[idx] <= addr;
        data[idx] <= mem_q[addr];
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
        resp_rdata <= mem_q[addr];
      end
      if (state == RESP)
        for (int i = 0; i < LINES; i++)
          age[i] <= IW'(i) == idx ? '0 : age[i] < age[idx] ? age[i] + 1'b1 : age[i];
    end
  end
  // Backing RAM words carry their power-up image and are never touched by reset
  for (genvar g = 0; g < 2**ADDR_W; g++) begin : ram
    logic [DATA_W-1:0] w = DATA_W'(g);
    always_ff @(posedge clock)
      if (ram_we && tag[idx] == ADDR_W'(g)) w <= data[idx];
    assign mem_q[g] = w;
  end
`ifdef CACHE_STATS_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      hit_count <= '0;
      miss_count <= '0;
    end else if (resp_valid) begin
      if (resp_hit && hit_count != 16'hFFFF) hit_count <= hit_count + 1'b1;
      if (!resp_hit && miss_count != 16'hFFFF) miss_count <= miss_count + 1'b1;
    end
`endif
endmodule
